// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB sizing, NULL RB index and packed FU bus slice helpers.
package cdb_arbiter_pkg;
  localparam int FU_NUM    = 4;
  localparam int WORD_SIZE = 32;
  localparam int RB_INDEX  = 4;
  localparam int FU_INDEX  = 2;
  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [RB_INDEX-1:0]  rb_idx_t;
  typedef logic [FU_INDEX-1:0]  fu_id_t;
  localparam rb_idx_t RB_NULL = '0;
  function automatic word_t fu_word(input logic [FU_NUM*WORD_SIZE-1:0] bus, input fu_id_t i);
    return bus[i*WORD_SIZE +: WORD_SIZE];
  endfunction
  function automatic rb_idx_t fu_rb(input logic [FU_NUM*RB_INDEX-1:0] bus, input fu_id_t i);
    return bus[i*RB_INDEX +: RB_INDEX];
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// cdb_arbiter_rr_pick: combinational round-robin picker, first request at or above ptr_i with wrap.
module cdb_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] winner_o,
  output logic         any_o
);
  always_comb begin
    logic [W-1:0] idx;
    idx      = '0;
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        any_o       = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o    = idx;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the ROB writeback bus with a one-entry output stage.
// Define CDB_ARB_STATS_EN to add per-FU grant counters and a stall counter.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FU_NUM-1:0]             fu_valid,
  input  logic [FU_NUM*WORD_SIZE-1:0]   fu_data,
  input  logic [FU_NUM*RB_INDEX-1:0]    fu_rb_index,
  output logic [FU_NUM-1:0]             fu_ack,
  input  logic                          flush,
  input  logic                          rb_ready,
  output logic                          cdb_valid,
  output logic [WORD_SIZE-1:0]          cdb_data,
  output logic [RB_INDEX-1:0]           cdb_rb_index,
  output logic [FU_INDEX-1:0]           cdb_fu
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [FU_NUM*16-1:0]          grant_count,
  output logic [15:0]                   stall_count
`endif
);
  logic          valid_q, valid_d;
  word_t         data_q, data_d;
  rb_idx_t       idx_q, idx_d;
  fu_id_t        fu_q, fu_d, ptr_q, ptr_d, winner;
  logic [FU_NUM-1:0] grant;
  logic          any, load;

  cdb_arbiter_rr_pick #(.N(FU_NUM), .W(FU_INDEX)) u_pick (
    .req_i(fu_valid), .ptr_i(ptr_q), .grant_o(grant), .winner_o(winner), .any_o(any)
  );

  assign load   = !flush && (!valid_q || rb_ready);
  // Gated by reset so no FU releases an entry while the stage is being cleared.
  assign fu_ack = (reset && load && any) ? grant : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    fu_d    = fu_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = 1'b0;
      idx_d   = RB_NULL;
    end else if (load) begin
      valid_d = any;
      data_d  = any ? fu_word(fu_data, winner) : data_q;
      idx_d   = any ? fu_rb(fu_rb_index, winner) : idx_q;
      fu_d    = any ? winner : fu_q;
      ptr_d   = !any ? ptr_q : (winner == FU_INDEX'(FU_NUM-1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= RB_NULL;
      fu_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      fu_q    <= fu_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cdb_valid    = valid_q;
  assign cdb_data     = data_q;
  assign cdb_rb_index = idx_q;
  assign cdb_fu       = fu_q;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] stall_q;
  for (genvar g = 0; g < FU_NUM; g++) begin : g_gcnt
    logic [15:0] gcnt_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) gcnt_q <= '0;
      else if (fu_ack[g] && gcnt_q != 16'hFFFF) gcnt_q <= gcnt_q + 16'd1;
    end
    assign grant_count[g*16 +: 16] = gcnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else if (valid_q && !rb_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, corner sequences and a randomized reference-model run.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] fu_valid, fu_ack;
  logic [127:0] fu_data;
  logic [15:0] fu_rb_index;
  logic flush, rb_ready, cdb_valid;
  logic [31:0] cdb_data;
  logic [3:0] cdb_rb_index;
  logic [1:0] cdb_fu;
`ifdef CDB_ARB_STATS_EN
  logic [63:0] grant_count;
  logic [15:0] stall_count;
`endif
  int checks = 0, passed = 0;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .fu_valid(fu_valid), .fu_data(fu_data),
    .fu_rb_index(fu_rb_index), .fu_ack(fu_ack), .flush(flush), .rb_ready(rb_ready),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rb_index(cdb_rb_index), .cdb_fu(cdb_fu)
`ifdef CDB_ARB_STATS_EN
    , .grant_count(grant_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] fv;
    logic       rdy;
    logic       fl;
    logic [3:0] ack;
    logic       v;
    logic [1:0] fu;
    logic [3:0] idx;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fixed_data();
    for (int i = 0; i < 4; i++) begin
      fu_data[i*32 +: 32]    = 32'hA000_0000 + 32'(i);
      fu_rb_index[i*4 +: 4]  = 4'(i + 3);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; fu_valid = '0; flush = 1'b0; rb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model state for the random run
  bit          m_v;
  logic [31:0] m_d;
  logic [3:0]  m_i;
  logic [1:0]  m_f;
  int          m_ptr;
  bit          pend[4];
  logic [31:0] pd[4];
  logic [3:0]  pix[4];

  initial begin
    fu_valid = '0; flush = 1'b0; rb_ready = 1'b1; fu_data = '0; fu_rb_index = '0;
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd3};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd4};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd5};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd6};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd3};
    tbl[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd5};
    tbl[6]  = '{4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd5};
    tbl[7]  = '{4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd5};
    tbl[8]  = '{4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd5};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd6};
    tbl[10] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd3};
    tbl[11] = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd4};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 4'd4};
    tbl[14] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd6};
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4'd6};

    // Reset state, with requests pending while reset is held
    fu_valid = 4'b1111;
    #3;
    chk("reset_ack", fu_ack, 4'b0000);
    chk("reset_valid", cdb_valid, 1'b0);
    chk("reset_data", cdb_data, 32'h0);
    chk("reset_idx", cdb_rb_index, RB_NULL);
    chk("reset_fu", cdb_fu, 2'd0);
    do_reset();

    // Single request from FU1
    fu_data[63:32] = 32'h0000_0007; fu_rb_index[7:4] = 4'd5;
    fu_valid = 4'b0010;
    #1 chk("single_ack", fu_ack, 4'b0010);
    @(negedge clk);
    fu_valid = 4'b0000;
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_data", cdb_data, 32'h7);
    chk("single_idx", cdb_rb_index, 4'd5);
    chk("single_fu", cdb_fu, 2'd1);
    @(negedge clk);
    chk("single_drain", cdb_valid, 1'b0);

    // Directed table from a fresh pointer
    fixed_data();
    do_reset();
    for (int r = 0; r < 16; r++) begin
      fu_valid = tbl[r].fv; rb_ready = tbl[r].rdy; flush = tbl[r].fl;
      #1 chk($sformatf("tbl%0d_ack", r), fu_ack, tbl[r].ack);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), cdb_valid, tbl[r].v);
      chk($sformatf("tbl%0d_fu", r), cdb_fu, tbl[r].fu);
      chk($sformatf("tbl%0d_idx", r), cdb_rb_index, tbl[r].idx);
      chk($sformatf("tbl%0d_data", r), cdb_data, 32'hA000_0000 + 32'(tbl[r].fu));
    end

    // Reset pulsed mid-stall between edges
    fu_valid = 4'b0100; rb_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk("stall_load_fu", cdb_fu, 2'd2);
    fu_valid = 4'b1111; rb_ready = 1'b0;
    #1 chk("stall_ack", fu_ack, 4'b0000);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("midreset_valid", cdb_valid, 1'b0);
    chk("midreset_ack", fu_ack, 4'b0000);
    #1 reset = 1'b1;
    @(negedge clk);
    rb_ready = 1'b1;
    #1 chk("midreset_first_grant", fu_ack, 4'b0001);
    @(negedge clk);
    chk("midreset_first_fu", cdb_fu, 2'd0);

`ifdef CDB_ARB_STATS_EN
    do_reset();
    fixed_data();
    fu_valid = 4'b0010; rb_ready = 1'b1;
    repeat (10) @(negedge clk);
    fu_valid = 4'b0000; rb_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("stats_grant1", grant_count[31:16], 16'd10);
    chk("stats_grant0", grant_count[15:0], 16'd0);
    chk("stats_stall", stall_count, 16'd4);
    rb_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("stats_grant1_flush", grant_count[31:16], 16'd10);
    chk("stats_stall_flush", stall_count, 16'd4);
`endif

    // Randomized run against the reference model
    do_reset();
    m_v = 1'b0; m_d = '0; m_i = RB_NULL; m_f = '0; m_ptr = 0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int  win;
      bit  ld;
      logic [3:0] exp_ack;
      chk("rnd_valid", cdb_valid, m_v);
      chk("rnd_data", cdb_data, m_d);
      chk("rnd_idx", cdb_rb_index, m_i);
      chk("rnd_fu", cdb_fu, m_f);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; pd[i] = $urandom; pix[i] = 4'($urandom_range(0, 15));
        end
        fu_valid[i] = pend[i];
        fu_data[i*32 +: 32] = pd[i];
        fu_rb_index[i*4 +: 4] = pix[i];
      end
      rb_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      #1;
      ld = !flush && (!m_v || rb_ready);
      win = -1;
      if (ld)
        for (int k = 0; k < 4; k++)
          if (win < 0 && pend[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      exp_ack = (win >= 0) ? 4'(1 << win) : 4'b0000;
      chk("rnd_ack", fu_ack, exp_ack);
      if (flush) begin
        m_v = 1'b0; m_i = RB_NULL;
      end else if (ld) begin
        m_v = win >= 0;
        if (win >= 0) begin
          m_d = pd[win]; m_i = pix[win]; m_f = 2'(win);
          m_ptr = (win + 1) % 4;
          pend[win] = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common-data-bus writeback port of the reorder buffer between FU_NUM functional-unit reservation stations.
- Each FU presents a result as valid + data + RB index. The arbiter picks one per cycle round-robin, registers it into a one-entry output stage and acks the winner so it can release its entry.
- The output stage holds until the reorder buffer accepts it (rb_ready).
- A flush input drops any in-flight result on a mispredict or exception.

Parameters:
- FU_NUM, 4, number of requesting functional units
- WORD_SIZE, 32, result data width
- RB_INDEX, 4, reorder-buffer index width
- FU_INDEX, 2, width of the FU id; must satisfy 2**FU_INDEX >= FU_NUM

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fu_valid  input  FU_NUM  bit i: FU i holds a finished result
- fu_data  input  FU_NUM*WORD_SIZE  result of FU i at bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]
- fu_rb_index  input  FU_NUM*RB_INDEX  destination RB entry of FU i, packed the same way
- fu_ack  output  FU_NUM  one-hot; bit i high means FU i's result was taken this cycle
- flush  input  1  synchronous; discard the output stage
- rb_ready  input  1  reorder buffer accepts the CDB word this cycle
- cdb_valid  output  1  CDB word present
- cdb_data  output  WORD_SIZE  broadcast result
- cdb_rb_index  output  RB_INDEX  destination RB entry
- cdb_fu  output  FU_INDEX  id of the source FU

Behaviour:
- Reset (reset low, asynchronous):
  - cdb_valid = 0, cdb_data = 0, cdb_rb_index = NULL, cdb_fu = 0.
  - Round-robin pointer = 0 (FU 0 has highest priority).
  - fu_ack = 0 while reset is asserted.
- Handshake with the FUs:
  - An FU raises fu_valid and holds it, with data and index stable, until it sees fu_ack in that cycle.
  - It drops fu_valid in the following cycle unless it has a new result.
- Load condition: load = !flush && (!cdb_valid || rb_ready).
- Arbitration (combinational):
  - Search fu_valid from pointer upward, wrapping modulo FU_NUM.
  - The first set bit is the winner.
- fu_ack = one-hot(winner) when load is true and any fu_valid is set; otherwise 0.
- Clock edge with load and a winner:
  - Output stage takes the winner's data, rb_index and id; cdb_valid <= 1.
  - pointer <= (winner+1) mod FU_NUM.
- Clock edge with load and no request: cdb_valid <= 0; data, index and fu fields are held; pointer unchanged.
- Clock edge without load (stall: cdb_valid && !rb_ready): all output registers and the pointer are held, and fu_ack = 0.
- Flush (takes priority over everything):
  - cdb_valid <= 0, cdb_rb_index <= NULL.
  - fu_ack = 0 that cycle; pointer held.
  - Requesters keep their requests and compete again the next cycle.
- Latency:
  - A request in cycle N with the stage free or draining gives cdb_valid in cycle N+1.
  - Throughput is one result per cycle with rb_ready held high.
- Simultaneous drain and fill: when rb_ready and cdb_valid are both high in the same cycle as a new winner, the stage is refilled back-to-back with no bubble.
- Fairness: a continuously requesting FU is granted within FU_NUM loads.
- fu_valid bits for indices >= FU_NUM do not exist; a pointer wrap from FU_NUM-1 goes to 0.

Optional Feature:
- Macro: CDB_ARB_STATS_EN
- When defined, the block adds these outputs:
  - grant_count: FU_NUM*16 bits, per-FU saturating counters incremented on each ack.
  - stall_count: 16 bits, saturating count of cycles with cdb_valid && !rb_ready.
- Both counters clear on reset. Flush does not clear them.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- The shared parameters header provides:
  - WORD_SIZE, RB_INDEX, FU_NUM, FU_INDEX
  - the NULL RB index constant
  - slice helpers for packed FU buses (the same packing the reservation stations already drive).
- One natural sub-module, rr_pick:
  - Purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded winner and any-request flag.
  - Reusable for issue arbitration.

Test Plan:
- Single request: fu_valid=0010, fu_data[1]=32'h0000_0007, rb_index 5, rb_ready=1 -> fu_ack=0010 in cycle 0; cycle 1 shows cdb_valid=1, cdb_data=7, cdb_rb_index=5, cdb_fu=1.
- Round-robin: all four FUs request continuously, rb_ready=1 from reset -> grant order 0,1,2,3,0; one cdb_valid per cycle with no bubbles.
- Back-pressure:
  - FU2 result loaded, then rb_ready=0 for 3 cycles while FU3 requests.
  - cdb_* holds FU2's word and fu_ack=0 for all 3 cycles.
  - Result arrives from FU3 (cdb_fu=3) in the cycle after rb_ready returns to 1.
- Flush:
  - cdb_valid=1 with FU0's word; flush=1 while FU1 requests.
  - Next cycle cdb_valid=0, cdb_rb_index=NULL, and no ack that cycle.
  - FU1 is granted in the following cycle.
- Reset mid-stall: with cdb_valid=1 and rb_ready=0, pulse reset low asynchronously between edges -> cdb_valid drops immediately, pointer returns to 0, and with all requests pending the first grant after release goes to FU0.
- With CDB_ARB_STATS_EN: 10 grants to FU1 and 4 stall cycles -> grant_count[1]=10, stall_count=4; after flush the values are unchanged.
